app_level_resp_return: RTL

APP_LEVEL_RESP_RETURN -- requirements
Module: app_level_resp_return

---
 rtl/app_level_resp_return.sv | 105 ++++++++++
 1 files changed

// File: rtl/app_level_resp_return.sv
// Response return path: buffers downstream read responses in order for the app and
// tracks issue credits (in-flight to downstream, outstanding until delivered to app).
module app_level_resp_return #(
    parameter int unsigned DATA_WIDTH      = 512,
    parameter int unsigned SIZE_WIDTH      = 64,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 15,
    localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enabled,
    input  logic                  req_issued,
    input  logic                  memResp_valid,
    input  logic [DATA_WIDTH-1:0] memResp_data,
    input  logic [SIZE_WIDTH-1:0] memResp_size,
    output logic                  memResp_grant,
    output logic                  appResp_valid,
    output logic [DATA_WIDTH-1:0] appResp_data,
    output logic [SIZE_WIDTH-1:0] appResp_size,
    input  logic                  appResp_ready,
    output logic                  can_issue,
    output logic [CW-1:0]         outstanding,
    output logic                  err_unexpected,
    output logic                  err_overissue
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = DATA_WIDTH + SIZE_WIDTH;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [NW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic          err_unexpected_q, err_overissue_q;
    logic          issue_ok, expected, push, pop;
    logic [EW-1:0] head;

    assign can_issue = enabled & (outstanding_q < CW'(MAX_OUTSTANDING));
    assign issue_ok  = req_issued & can_issue;
    // A response is legitimate if a read is in flight or one is being issued this cycle.
    assign expected  = (inflight_q != '0) | issue_ok;

    assign memResp_grant = ~rst & memResp_valid & (count_q < NW'(FIFO_DEPTH));
    assign push          = memResp_grant & expected;
    assign appResp_valid = ~rst & (count_q != '0);
    assign pop           = appResp_valid & appResp_ready;

    assign head         = appResp_valid ? mem_q[rd_ptr_q] : '0;
    assign appResp_data = head[EW-1:SIZE_WIDTH];
    assign appResp_size = head[SIZE_WIDTH-1:0];

    assign outstanding    = outstanding_q;
    assign err_unexpected = err_unexpected_q;
    assign err_overissue  = err_overissue_q;

    always_comb begin
        count_d       = count_q;
        inflight_d    = inflight_q;
        outstanding_d = outstanding_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        unique case ({issue_ok, push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
        unique case ({issue_ok, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q          <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            inflight_q       <= '0;
            outstanding_q    <= '0;
            err_unexpected_q <= 1'b0;
            err_overissue_q  <= 1'b0;
        end else begin
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            outstanding_q <= outstanding_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (memResp_grant & ~expected) err_unexpected_q <= 1'b1;
            if (req_issued & ~can_issue)   err_overissue_q  <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {memResp_data, memResp_size};
    end

endmodule
